// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths common to the master bridge and the memory slave,
// plus the master bridge state encoding.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// ACCESS-phase cycle counter: flags when pready may be sampled and when the slave
// has taken too long to respond.
module apb_wait_counter #(
  parameter int unsigned ACCESS_MIN = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic pclk,
  input  logic prst,
  input  logic clear,
  input  logic enable,
  output logic sample_ok,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  // Comparisons use one extra bit so count+1 never overflows.
  localparam logic [CntW:0] OneC        = (CntW + 1)'(1);
  localparam logic [CntW:0] AccessMinC  = (CntW + 1)'(ACCESS_MIN);
  localparam logic [CntW:0] TimeoutC    = (CntW + 1)'(TIMEOUT);

  logic [CntW-1:0] count_q, count_d;
  logic [CntW:0]   count_inc;

  always_comb begin
    count_inc = {1'b0, count_q} + OneC;
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_inc[CntW-1:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sample_ok = (count_inc >= AccessMinC);
  assign expired   = (count_inc == TimeoutC);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: takes one command at a time, runs SETUP/ACCESS on the bus and returns
// read data or a timeout error on a valid/ready response channel.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = APB_ADDR_W,
  parameter int unsigned DATA_W     = APB_DATA_W,
  parameter int unsigned ACCESS_MIN = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_write,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  apb_mst_state_t state_q, state_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_write_q, rsp_write_d;

  logic sample_ok;
  logic expired;

  apb_wait_counter #(
    .ACCESS_MIN (ACCESS_MIN),
    .TIMEOUT    (TIMEOUT)
  ) u_wait_counter (
    .pclk      (pclk),
    .prst      (prst),
    .clear     (state_q == SETUP),
    .enable    (state_q == ACCESS),
    .sample_ok (sample_ok),
    .expired   (expired)
  );

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_write_d = rsp_write_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave beats a simultaneous timeout.
        if (sample_ok && pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = 1'b0;
          rsp_write_d = pwrite_q;
          state_d     = RESP;
        end else if (expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_write_d = pwrite_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus controls are registered copies of the next-state decode.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_write = rsp_write_q;

endmodule
